pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Pipeline sequencer for the 5-stage MIPS core: drives PC/IF-ID/ID-EX/EX-MEM enables and flushes.
// - Inputs: decoded rs/rt from ID, load/mul-div/redirect status from EX, and a memory-wait line.
// - Handles load-use interlock, HI/LO busy interlock, branch/jump flush and global freeze.
// PARAMETERS
// - LOAD_STALL_CYC  1   bubbles inserted per load-use hazard (1..3)
// - MD_LAT          32  cycles a mult/div occupies HI/LO after md_start (1..63)
// - FLUSH_EXTRA     0   extra IF-ID flush cycles after a redirect (0..3)
// PORTS
// - clk          in   1   core clock
// - rst          in   1   reset: asynchronous, active-high
// - id_rs        in   5   rs field of the instruction in ID
// - id_rt        in   5   rt field of the instruction in ID
// - id_uses_rs   in   1   ID instruction reads rs
// - id_uses_rt   in   1   ID instruction reads rt
// - id_uses_hilo in   1   ID instruction is mfhi/mflo/mthi/mtlo
// - ex_MemRead   in   1   instruction in EX is a load
// - ex_wreg      in   5   destination register of the instruction in EX
// - ex_redirect  in   1   EX resolved a taken branch/jump (level, valid one cycle)
// - md_start     in   1   EX issues a mult/div this cycle
// - mem_wait     in   1   data/instr memory not ready; freeze the pipe
// - pc_en        out  1   PC register load enable
// - ifid_en      out  1   IF-ID register enable
// - ifid_flush   out  1   IF-ID register clear (bubble)
// - idex_en      out  1   ID-EX register enable
// - idex_flush   out  1   ID-EX register clear (bubble)
// - exmem_en     out  1   EX-MEM and MEM-WB enable
// - md_busy      out  1   HI/LO result not yet valid
// BEHAVIOUR
// - Reset (async, while rst=1): state=RUN, counters=0, md_busy=0, all *_en=0, both flushes=1.
// - States: RUN, LSTALL, HSTALL, FLUSH; a 2-bit stall counter; a 6-bit md counter.
// - Priority per cycle: mem_wait > ex_redirect > load-use > hilo-busy.
// - mem_wait=1: every *_en=0, flushes=0, state and stall counter hold; md counter keeps counting; redirect ignored (EX holds it).
// - Redirect (RUN/LSTALL/HSTALL): same cycle pc_en=1, ifid_flush=1, idex_flush=1; -> FLUSH if FLUSH_EXTRA>0 (cnt=FLUSH_EXTRA) else RUN; aborts any stall.
// - FLUSH: ifid_flush=1, all enables 1; cnt-- ; cnt==1 -> RUN.
// - Load-use hit: ex_MemRead & ex_wreg!=0 & ((id_uses_rs & id_rs==ex_wreg)|(id_uses_rt & id_rt==ex_wreg)).
// - Hit in RUN: combinationally pc_en=0, ifid_en=0, idex_flush=1; if LOAD_STALL_CYC>1 -> LSTALL, cnt=LOAD_STALL_CYC-1.
// - LSTALL: same outputs as hit; cnt-- ; cnt==1 -> RUN. Hazard is not re-evaluated until back in RUN.
// - md_start: md counter := MD_LAT (reload even if busy); md_busy = (md counter != 0); decrements each cycle.
// - HI/LO hit: id_uses_hilo & md_busy (or md_start same cycle) -> pc_en=0, ifid_en=0, idex_flush=1; state HSTALL until md_busy=0, then RUN next cycle.
// - RUN without events: pc_en=ifid_en=idex_en=exmem_en=1, flushes=0.
// - idex_en and exmem_en are 0 only under mem_wait or reset.
// - All outputs are combinational from state/inputs; no registered output latency.
// CONFIGURATION
// - Macro PIPE_HAZARD_PERF_EN: when defined, adds outputs perf_stall_cnt[31:0] (cycles with pc_en=0 and mem_wait=0)
//   and perf_flush_cnt[31:0] (cycles with ifid_flush=1, excluding reset); both reset to 0 and wrap at 2^32.
// - Without the macro: ports and counters absent; behaviour otherwise identical.
// TESTING
// - lw $5 in EX, ID add $6,$5,$1 (uses_rs, rs=5) -> exactly 1 cycle pc_en=0,ifid_en=0,idex_flush=1, then RUN.
// - Same with ex_wreg=0 or id_uses_rs=0 -> no stall; LOAD_STALL_CYC=3 -> 3 bubble cycles.
// - md_start, then mflo in ID next cycle, MD_LAT=32 -> stall until md_busy falls (32 cycles), mflo advances next cycle.
// - ex_redirect with simultaneous load-use hit, FLUSH_EXTRA=1 -> pc_en=1, both flushes=1, then 1 cycle ifid_flush=1, then RUN.
// - mem_wait=1 for 5 cycles during LSTALL -> all enables 0, stall count frozen, resumes exactly where left.
// - rst asserted mid-HSTALL -> immediate md_busy=0, enables 0, flushes 1; on release RUN, enables 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX status in, stage enables/flushes out.
// Perf counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_uses_hilo;
    logic        ex_MemRead;
    logic [4:0]  ex_wreg;
    logic        ex_redirect;
    logic        md_start;
    logic        mem_wait;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        md_busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
        output ex_MemRead, ex_wreg, ex_redirect, md_start, mem_wait,
`ifdef PIPE_HAZARD_PERF_EN
        input  perf_stall_cnt, perf_flush_cnt,
`endif
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        input  exmem_en, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo,
        input  ex_MemRead, ex_wreg, ex_redirect, md_start, mem_wait,
`ifdef PIPE_HAZARD_PERF_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        output exmem_en, md_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use / HI-LO interlocks, redirect flush, freeze.
// Optional macro PIPE_HAZARD_PERF_EN adds stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int MD_LAT         = 32,
    parameter int FLUSH_EXTRA    = 0
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {RUN, LSTALL, HSTALL, FLUSH} state_t;

    localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYC - 1);
    localparam logic [1:0] FX_INIT = 2'(FLUSH_EXTRA);
    localparam logic [5:0] MD_INIT = 6'(MD_LAT);

    state_t     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic [5:0] md_cnt;
    logic       md_busy;
    logic       load_hit, hilo_hit;
    logic       pc_en, ifid_en, ifid_flush;
    logic       idex_en, idex_flush, exmem_en;

    assign md_busy  = (md_cnt != 6'd0);
    assign load_hit = bus.ex_MemRead && (bus.ex_wreg != 5'd0) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_wreg)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_wreg)));
    assign hilo_hit = bus.id_uses_hilo && (md_busy || bus.md_start);

    // Stage controls and next state, priority freeze > redirect > load > hilo.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        state_nx   = state;
        cnt_nx     = cnt;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_en    = 1'b0;
            idex_flush = 1'b1;
            exmem_en   = 1'b0;
        end else if (bus.mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (bus.ex_redirect && state != FLUSH) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FLUSH_EXTRA > 0) begin
                state_nx = FLUSH;
                cnt_nx   = FX_INIT;
            end else begin
                state_nx = RUN;
                cnt_nx   = 2'd0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (load_hit) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            state_nx = LSTALL;
                            cnt_nx   = LS_INIT;
                        end
                    end else if (hilo_hit) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        state_nx   = HSTALL;
                    end
                end
                LSTALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (cnt == 2'd1) state_nx = RUN;
                    cnt_nx = cnt - 2'd1;
                end
                HSTALL: begin
                    if (md_busy || bus.md_start) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else begin
                        state_nx = RUN;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    if (cnt == 2'd1) state_nx = RUN;
                    cnt_nx = cnt - 2'd1;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // Sequencer state; held while memory freezes the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else if (!bus.mem_wait) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // HI/LO occupancy timer; runs even during a freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               md_cnt <= 6'd0;
        else if (bus.md_start) md_cnt <= MD_INIT;
        else if (md_busy)      md_cnt <= md_cnt - 6'd1;
    end

    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_en    = idex_en;
    assign bus.idex_flush = idex_flush;
    assign bus.exmem_en   = exmem_en;
    assign bus.md_busy    = md_busy;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;

    // Stall and flush cycle counters, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= 32'd0;
            perf_flush <= 32'd0;
        end else begin
            if (!pc_en && !bus.mem_wait) perf_stall <= perf_stall + 32'd1;
            if (ifid_flush)              perf_flush <= perf_flush + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = perf_stall;
    assign bus.perf_flush_cnt = perf_flush;
`else
    // Counters absent in this build.
`endif

endmodule
